// File: rtl/qam_demapper_stream_if.sv
// -----------------------------------------------------------------------------
// qam_demapper_stream_if
// Purpose : Groups the receive-side and transmit-side valid/ready streams of the
//           QAM hard-decision demapper into one bundle.
// Modports:
//   master - the surrounding logic: drives samples and out_ready, observes
//            in_ready and the demapped beat.
//   slave  - the demapper itself.
// Signals :
//   in_valid/in_ready/in_i/in_q/mod    equalised subcarrier stream
//   out_valid/out_ready/out_bits/
//   out_nbits/out_last                 demapped bit stream
// -----------------------------------------------------------------------------
interface qam_demapper_stream_if #(
    parameter int W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_i;
    logic signed [W-1:0] in_q;
    logic [1:0]          mod;
    logic                out_valid;
    logic                out_ready;
    logic [5:0]          out_bits;
    logic [2:0]          out_nbits;
    logic                out_last;

    modport master (
        output in_valid, in_i, in_q, mod, out_ready,
        input  in_ready, out_valid, out_bits, out_nbits, out_last
    );

    modport slave (
        input  in_valid, in_i, in_q, mod, out_ready,
        output in_ready, out_valid, out_bits, out_nbits, out_last
    );
endinterface

// File: rtl/qam_demapper_stream.sv
// -----------------------------------------------------------------------------
// qam_demapper_stream
// Purpose : Streaming hard-decision demapper (BPSK/QPSK/16-QAM/64-QAM, Gray)
//           for the 802.11a receive path. Slices each equalised subcarrier by
//           nearest-point thresholds, counts subcarriers per OFDM symbol and
//           flags the last one. Two register stages, one beat per cycle.
// Ports   :
//   clk  - rising-edge clock
//   rst  - synchronous reset, active high
//   bus  - qam_demapper_stream_if.slave (input and output streams)
// -----------------------------------------------------------------------------
module qam_demapper_stream #(
    parameter int W    = 8,
    parameter int UNIT = 16,
    parameter int N_SC = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    qam_demapper_stream_if.slave   bus
);
    localparam int CW = (N_SC > 1) ? $clog2(N_SC) : 1;

    // Decision thresholds on |x|, sized to the magnitude width
    localparam logic [W:0] T2 = (W+1)'(2 * UNIT);
    localparam logic [W:0] T4 = (W+1)'(4 * UNIT);
    localparam logic [W:0] T6 = (W+1)'(6 * UNIT);
    localparam logic [CW-1:0] SC_LAST = CW'(N_SC - 1);

    // Magnitude with one extra bit so the most negative sample does not wrap
    function automatic logic [W:0] abs_ext(input logic [W-1:0] x);
        logic [W:0] e;
        e = {x[W-1], x};
        if (x[W-1]) begin
            abs_ext = ~e + (W+1)'(1);
        end else begin
            abs_ext = e;
        end
    endfunction

    // Per-axis slice; returns {b2, b1, b0} with unused bits zero
    function automatic logic [2:0] slice_axis(input logic [W:0] a,
                                              input logic       sgn,
                                              input logic [1:0] m);
        case (m)
            2'd2:    slice_axis = {1'b0, (a < T2), sgn};
            2'd3:    slice_axis = {((a >= T2) && (a < T6)), (a < T4), sgn};
            default: slice_axis = {2'b00, sgn};
        endcase
    endfunction

    logic            w_en;
    logic            w_acc;
    logic [1:0]      w_mod_use;
    logic [2:0]      w_dec_i;
    logic [2:0]      w_dec_q;
    logic [5:0]      w_bits;
    logic [2:0]      w_nbits;

    logic [CW-1:0]   r_sc_cnt;
    logic [1:0]      r_mod;

    logic            r_s1_valid;
    logic [W:0]      r_s1_abs_i;
    logic [W:0]      r_s1_abs_q;
    logic            r_s1_sgn_i;
    logic            r_s1_sgn_q;
    logic [1:0]      r_s1_mod;
    logic            r_s1_last;

    logic            r_s2_valid;
    logic [5:0]      r_s2_bits;
    logic [2:0]      r_s2_nbits;
    logic            r_s2_last;

    // Whole pipeline advances together whenever the output slot can move
    assign w_en  = !r_s2_valid || bus.out_ready;
    assign w_acc = bus.in_valid && w_en;

    // First subcarrier of a symbol takes mod straight from the port so the
    // latch and its first use happen in the same beat
    always_comb begin
        w_mod_use = r_mod;
        if (r_sc_cnt == {CW{1'b0}}) begin
            w_mod_use = bus.mod;
        end else begin
            w_mod_use = r_mod;
        end
    end

    // Decision logic feeding the output registers
    always_comb begin
        w_dec_i = slice_axis(r_s1_abs_i, r_s1_sgn_i, r_s1_mod);
        w_dec_q = slice_axis(r_s1_abs_q, r_s1_sgn_q, r_s1_mod);
        w_bits  = 6'd0;
        w_nbits = 3'd1;
        case (r_s1_mod)
            2'd0: begin
                w_bits  = {5'd0, w_dec_i[0]};
                w_nbits = 3'd1;
            end
            2'd1: begin
                w_bits  = {4'd0, w_dec_q[0], w_dec_i[0]};
                w_nbits = 3'd2;
            end
            2'd2: begin
                w_bits  = {2'd0, w_dec_q[1:0], w_dec_i[1:0]};
                w_nbits = 3'd4;
            end
            2'd3: begin
                w_bits  = {w_dec_q, w_dec_i};
                w_nbits = 3'd6;
            end
            default: begin
                w_bits  = 6'd0;
                w_nbits = 3'd1;
            end
        endcase
    end

    // Subcarrier counter and per-symbol modulation latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc_cnt <= {CW{1'b0}};
            r_mod    <= 2'd0;
        end else if (w_acc) begin
            if (r_sc_cnt == {CW{1'b0}}) begin
                r_mod <= bus.mod;
            end
            if (r_sc_cnt == SC_LAST) begin
                r_sc_cnt <= {CW{1'b0}};
            end else begin
                r_sc_cnt <= r_sc_cnt + CW'(1);
            end
        end
    end

    // Stage 1: magnitudes, signs, modulation and last flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_abs_i <= {(W+1){1'b0}};
            r_s1_abs_q <= {(W+1){1'b0}};
            r_s1_sgn_i <= 1'b0;
            r_s1_sgn_q <= 1'b0;
            r_s1_mod   <= 2'd0;
            r_s1_last  <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_abs_i <= abs_ext(bus.in_i);
                r_s1_abs_q <= abs_ext(bus.in_q);
                r_s1_sgn_i <= ~bus.in_i[W-1];
                r_s1_sgn_q <= ~bus.in_q[W-1];
                r_s1_mod   <= w_mod_use;
                r_s1_last  <= (r_sc_cnt == SC_LAST);
            end
        end
    end

    // Stage 2: registered decisions driving the output stream
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_bits  <= 6'd0;
            r_s2_nbits <= 3'd0;
            r_s2_last  <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_bits  <= w_bits;
                r_s2_nbits <= w_nbits;
                r_s2_last  <= r_s1_last;
            end
        end
    end

    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_bits  = r_s2_bits;
    assign bus.out_nbits = r_s2_nbits;
    assign bus.out_last  = r_s2_last;
endmodule
